// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen
//
// Purpose: produces every COUNT_OF_BITS-bit word that has a requested number
// of ones, one word per handshake, in ascending numeric order. Words are
// stepped with the Gosper "next value with the same popcount" successor.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   req_valid  request offered
//   req_ready  block can accept a request (IDLE decode, combinational)
//   req_ones   requested popcount k
//   req_err    one-cycle pulse: accepted request had k > COUNT_OF_BITS
//   num        generated word
//   num_valid  num is valid
//   num_ready  consumer accepts num
//   num_last   num is the final word of the sequence
//   idx        (only with ONES_PATTERN_GEN_INDEX_EN) 0-based word position
//
// Build option: define ONES_PATTERN_GEN_INDEX_EN to add the idx output.

module ones_pattern_gen #(
  parameter int COUNT_OF_BITS = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [$clog2(COUNT_OF_BITS+1)-1:0]     req_ones,
  output logic                                   req_err,
  output logic [COUNT_OF_BITS-1:0]               num,
  output logic                                   num_valid,
  input  logic                                   num_ready,
  output logic                                   num_last
`ifdef ONES_PATTERN_GEN_INDEX_EN
  ,output int                                    idx
`endif
);

  localparam int unsigned KW = $clog2(COUNT_OF_BITS + 1);
  localparam logic [KW-1:0] N_K = KW'(COUNT_OF_BITS);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                   state_q;
  logic [COUNT_OF_BITS-1:0] num_q;
  logic                     valid_q;
  logic                     last_q;
  logic                     err_q;
  logic [KW-1:0]            k_q;

  logic [COUNT_OF_BITS-1:0] low_mask;
  logic [COUNT_OF_BITS-1:0] top_mask;
  logic                     first_last;
  logic [COUNT_OF_BITS-1:0] lsb;
  logic [COUNT_OF_BITS:0]   ripple;
  logic [COUNT_OF_BITS:0]   changed;
  logic [COUNT_OF_BITS:0]   succ_w;
  logic [COUNT_OF_BITS-1:0] num_d;
  logic                     last_d;
  int unsigned              tz;

  always_comb begin
    // First word: k low bits set. Last word: k top bits set.
    low_mask   = ~({COUNT_OF_BITS{1'b1}} << req_ones);
    top_mask   = ~({COUNT_OF_BITS{1'b1}} >> k_q);
    first_last = (req_ones == '0) || (req_ones == N_K);

    // Gosper successor, carried in N+1 bits so the carry out of the top
    // bit is never lost before the last-word comparison.
    lsb     = num_q & (-num_q);
    ripple  = {1'b0, num_q} + {1'b0, lsb};
    changed = {1'b0, num_q} ^ ripple;
    tz      = 0;
    for (int unsigned i = COUNT_OF_BITS; i > 0; i--) begin
      if (num_q[i-1]) tz = i - 1;
    end
    // Division by the lowest set bit is a shift by its position.
    succ_w = ripple | ((changed >> 2) >> tz);
    num_d  = succ_w[COUNT_OF_BITS-1:0];
    last_d = (succ_w == {1'b0, top_mask});
  end

`ifdef ONES_PATTERN_GEN_INDEX_EN
  int idx_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      k_q     <= '0;
`ifdef ONES_PATTERN_GEN_INDEX_EN
      idx_q   <= 0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (req_ones > N_K) begin
              err_q <= 1'b1;
            end else begin
              num_q   <= low_mask;
              valid_q <= 1'b1;
              last_q  <= first_last;
              k_q     <= req_ones;
              state_q <= RUN;
`ifdef ONES_PATTERN_GEN_INDEX_EN
              idx_q   <= 0;
`endif
            end
          end
        end
        RUN: begin
          if (num_ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= IDLE;
`ifdef ONES_PATTERN_GEN_INDEX_EN
              idx_q   <= 0;
`endif
            end else begin
              num_q  <= num_d;
              last_q <= last_d;
`ifdef ONES_PATTERN_GEN_INDEX_EN
              idx_q  <= idx_q + 1;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign req_err   = err_q;
  assign num       = num_q;
  assign num_valid = valid_q;
  assign num_last  = last_q;
`ifdef ONES_PATTERN_GEN_INDEX_EN
  assign idx       = idx_q;
`endif

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Testbench for ones_pattern_gen (N=4): directed requests push hand-computed
// word sequences into a scoreboard queue; a negedge monitor pops and compares
// on every num handshake, and also checks popcount loopback and stall holding.

module tb_ones_pattern_gen;

  localparam int N  = 4;
  localparam int KW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [KW-1:0] req_ones;
  logic          req_err;
  logic [N-1:0]  num;
  logic          num_valid;
  logic          num_ready;
  logic          num_last;
`ifdef ONES_PATTERN_GEN_INDEX_EN
  int            idx;
`endif

  always #5 clk = ~clk;

  ones_pattern_gen #(.COUNT_OF_BITS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ones  (req_ones),
    .req_err   (req_err),
    .num       (num),
    .num_valid (num_valid),
    .num_ready (num_ready),
    .num_last  (num_last)
`ifdef ONES_PATTERN_GEN_INDEX_EN
    ,.idx      (idx)
`endif
  );

  typedef struct packed {
    logic [N-1:0]  num;
    logic          last;
    logic [KW-1:0] k;
    int unsigned   idx;
  } exp_t;

  exp_t sb[$];

  // Hand-written sequences for k = 0..4, concatenated.
  logic [N-1:0] seq_tab [16] = '{4'b0000,
                                 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100,
                                 4'b0111, 4'b1011, 4'b1101, 4'b1110,
                                 4'b1111};
  int unsigned seq_off [5] = '{0, 1, 5, 11, 15};
  int unsigned seq_len [5] = '{1, 4, 6, 4, 1};

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  int err_exp  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor / scoreboard consumer.
  logic         hold_valid = 1'b0;
  logic [N-1:0] hold_num;
  logic         hold_last;

  always @(negedge clk) begin
    if (!rst) begin
      hold_valid = 1'b0;
    end else begin
      if (req_err) err_seen++;
      if (hold_valid) begin
        check("stall_valid", {31'd0, num_valid}, 32'd1);
        check("stall_num", {28'd0, num}, {28'd0, hold_num});
        check("stall_last", {31'd0, num_last}, {31'd0, hold_last});
      end
      hold_valid = num_valid && !num_ready;
      hold_num   = num;
      hold_last  = num_last;
      if (num_valid && num_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got %0h expected none", num);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("num", {28'd0, num}, {28'd0, e.num});
          check("num_last", {31'd0, num_last}, {31'd0, e.last});
          check("loop_ones", $countones(num), {29'd0, e.k});
          check("loop_zeros", N - $countones(num), N - {29'd0, e.k});
`ifdef ONES_PATTERN_GEN_INDEX_EN
          check("idx", idx, e.idx);
`endif
        end
      end
    end
  end

  // Called #1 after a posedge. Offers k, expects acceptance at the next edge.
  task automatic issue(input int unsigned k, input logic first_ready);
    req_valid = 1'b1;
    req_ones  = KW'(k);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    if (k <= N) begin
      for (int unsigned i = 0; i < seq_len[k]; i++)
        sb.push_back('{num: seq_tab[seq_off[k] + i], last: (i == seq_len[k] - 1),
                       k: KW'(k), idx: i});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    num_ready = first_ready;
  endtask

  // Steps num_ready through pat (then 1) until req_ready returns; checks cycle count.
  task automatic wait_done(input string name, input logic [15:0] pat, input int plen,
                           input int exp_cycles);
    int cycles;
    cycles = 0;
    while (!req_ready && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
      num_ready = (cycles < plen) ? pat[cycles] : 1'b1;
    end
    if (!req_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got busy expected idle", name);
    end else begin
      check(name, cycles, exp_cycles);
    end
    check({name, "_valid_low"}, {31'd0, num_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] stall_pat;
    stall_pat = 16'b0000_0000_0101_1001;  // bit i = num_ready in cycle i: 1,0,0,1,1,0,1
    rst = 1'b0; req_valid = 1'b0; req_ones = '0; num_ready = 1'b1;
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_num", {28'd0, num}, 32'd0);
    check("rst_num_valid", {31'd0, num_valid}, 32'd0);
    check("rst_num_last", {31'd0, num_last}, 32'd0);
    check("rst_req_err", {31'd0, req_err}, 32'd0);
`ifdef ONES_PATTERN_GEN_INDEX_EN
    check("rst_idx", idx, 32'd0);
`endif
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // k=2 streaming, then k=0 and k=4 back-to-back.
    issue(2, 1'b1);
    check("k2_first_valid", {31'd0, num_valid}, 32'd1);
    check("k2_busy", {31'd0, req_ready}, 32'd0);
    wait_done("k2_cycles", 16'hFFFF, 16, 6);
    issue(0, 1'b1);
    check("k0_last", {31'd0, num_last}, 32'd1);
    wait_done("k0_cycles", 16'hFFFF, 16, 1);
    issue(4, 1'b1);
    check("k4_last", {31'd0, num_last}, 32'd1);
    wait_done("k4_cycles", 16'hFFFF, 16, 1);

    // Out-of-range request.
    issue(5, 1'b1);
    err_exp++;
    check("k5_err_pulse", {31'd0, req_err}, 32'd1);
    check("k5_no_valid", {31'd0, num_valid}, 32'd0);
    check("k5_stay_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    check("k5_err_one_cycle", {31'd0, req_err}, 32'd0);
    check("k5_still_idle", {31'd0, num_valid}, 32'd0);

    // k=1 with consumer stalls.
    issue(1, stall_pat[0]);
    wait_done("k1_stall_cycles", stall_pat, 7, 7);

    // k=3 loopback, full run.
    issue(3, 1'b1);
    wait_done("k3_cycles", 16'hFFFF, 16, 4);

    // k=3 interrupted by reset after two words.
    issue(3, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, num_valid}, 32'd0);
    check("mid_rst_num", {28'd0, num}, 32'd0);
    check("mid_rst_last", {31'd0, num_last}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_err", {31'd0, req_err}, 32'd0);
`ifdef ONES_PATTERN_GEN_INDEX_EN
    check("mid_rst_idx", idx, 32'd0);
`endif
    check("mid_rst_pending", sb.size(), 32'd2);
    sb.delete();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    issue(1, 1'b1);
    check("after_rst_first", {28'd0, num}, 32'd1);
    wait_done("after_rst_cycles", 16'hFFFF, 16, 4);

    @(posedge clk); #1;
    check("err_pulses", err_seen, err_exp);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
